fetch_unit: RTL

//  Program-counter and fetch stage that sits directly upstream of the instruction memory.
//  - Drives the word address into the instruction memory.
//  - Latches the returned 32-bit word into an instruction register for decode.
//  - Applies stall, branch and jump redirects.
//  - Traps out-of-range targets in a sticky error state.

---
 rtl/fetch_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Program counter and fetch stage feeding the instruction memory and decode.
// Optional FETCH_COUNT_EN builds a delivered-instruction counter on fetch_count.
module fetch_unit #(
    parameter int unsigned MEM_DEPTH = 12,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        jump,
    input  logic [15:0] jump_target,
    output logic [15:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    output logic        addr_err,
    output logic [15:0] fetch_count
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    localparam logic [AW-1:0] LAST_PC  = AW'(MEM_DEPTH - 1);
    localparam logic [AW-1:0] RST_PC   = AW'(RESET_PC);
    localparam logic [AW:0]   DEPTH_WD = (AW + 1)'(MEM_DEPTH);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] instr_q, instr_d;
    logic [AW-1:0] instr_pc_q, instr_pc_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;

    logic          redirect;
    logic [AW-1:0] target;
    logic          target_ok;

    // Jump has priority; the range check only ever sees the winning target.
    assign redirect  = jump | branch_taken;
    assign target    = jump ? jump_target : branch_target;
    assign target_ok = {1'b0, target} < DEPTH_WD;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RST_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        err_d      = err_q;
        case (state_q)
            // Memory loads its image on the first edge, so nothing is fetched yet.
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    if (target_ok) begin
                        pc_d = target;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                        pc_d    = '0;
                    end
                end else if (!stall) begin
                    instr_d    = imem_data;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    pc_d       = (pc_q == LAST_PC) ? '0 : pc_q + AW'(1);
                end
            end
            ST_ERR: begin
                pc_d    = '0;
                valid_d = 1'b0;
                err_d   = 1'b1;
            end
            default: state_d = ST_BOOT;
        endcase
    end

`ifdef FETCH_COUNT_EN
    logic          load;
    logic [AW-1:0] count_q;

    assign load = (state_q == ST_RUN) && !redirect && !stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= count_q + AW'(1);
        end
    end

    assign fetch_count = count_q;
`else
    assign fetch_count = 16'h0000;
`endif

    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign addr_err    = err_q;

endmodule
